// File: rtl/uart_receiver_if.sv
// uart_receiver_if: receive-side bundle; parity_err exists only when UART_RX_PARITY_EN is defined
// Signals: rx serial line in; dataout byte, valid/frame_err[/parity_err] pulses and busy flag out of the receiver
interface uart_receiver_if;
  logic       rx;
  logic [7:0] dataout;
  logic       valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif
  modport master (
    output rx,
    input  dataout,
    input  valid,
    input  frame_err,
    input  busy
`ifdef UART_RX_PARITY_EN
    , input parity_err
`endif
  );
  modport slave (
    input  rx,
    output dataout,
    output valid,
    output frame_err,
    output busy
`ifdef UART_RX_PARITY_EN
    , output parity_err
`endif
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: UART receive stage, 8N1 by default, 8E1 with parity_err when UART_RX_PARITY_EN is defined
// Ports: ipclk clock; rst synchronous active-high reset; bus (slave) carries rx in and dataout/valid/frame_err/busy[/parity_err] out
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input logic            ipclk,
  input logic            rst,
  uart_receiver_if.slave bus
);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif
  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic [CW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d, dataout_q, dataout_d;
  logic          valid_q, valid_d, ferr_q, ferr_d;
  logic          bit_end;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d, perr_q, perr_d;
  assign bus.parity_err = perr_q;
`endif
  assign rx_s          = sync_q[1];
  assign bit_end       = timer_q == CW'(CLKS_PER_BIT - 1);
  assign bus.dataout   = dataout_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = state_q != IDLE;
  always_ff @(posedge ipclk) begin
    if (rst) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      timer_q   <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      dataout_q <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], bus.rx};
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      dataout_q <= dataout_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + CW'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    dataout_d = dataout_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        timer_d = '0;
        state_d = rx_s ? IDLE : START;
      end
      START: if (timer_q == CW'(HALF_BIT - 1)) begin
        timer_d = '0;
        idx_d   = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (bit_end) begin
        timer_d         = '0;
        shift_d[idx_q]  = rx_s;
        idx_d           = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        state_d = idx_q == 3'd7 ? PARITY : DATA;
`else
        state_d = idx_q == 3'd7 ? STOP : DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_end) begin
        timer_d = '0;
        par_d   = rx_s;
        state_d = STOP;
      end
`endif
      STOP: if (bit_end) begin
        // Leaving at mid-stop-bit lets a zero-gap start edge be caught from IDLE
        timer_d = '0;
        state_d = rx_s ? IDLE : WAIT_IDLE;
        ferr_d  = !rx_s;
`ifdef UART_RX_PARITY_EN
        perr_d    = rx_s && (^{shift_q, par_q});
        valid_d   = rx_s && !(^{shift_q, par_q});
`else
        valid_d   = rx_s;
`endif
        dataout_d = valid_d ? shift_q : dataout_q;
      end
      WAIT_IDLE: begin
        timer_d = '0;
        state_d = rx_s ? IDLE : WAIT_IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
